// File: rtl/bus_arbiter_2to1_pkg.sv
// Shared datapath definitions for the 2:1 bus arbiter: state encoding, source ids, data width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_arbiter_2to1_pkg;

    localparam int DATA_W = 32;

    // Source identifiers as carried on Sel / OutSrc.
    localparam logic SRC_A = 1'b1;
    localparam logic SRC_B = 1'b0;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_A = 2'b01,
        GRANT_B = 2'b10
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_2to1_mux.sv
// 32-bit 2-to-1 datapath mux; sel = 1 picks inA, sel = 0 picks inB.
// Latency: purely combinational.
// Backpressure: none, the mux has no flow control of its own.
// Ports: inA/inB data inputs, sel select, dout selected data.
module bus_arbiter_2to1_mux
    import bus_arbiter_2to1_pkg::*;
(
    input  logic [DATA_W-1:0] inA,
    input  logic [DATA_W-1:0] inB,
    input  logic              sel,
    output logic [DATA_W-1:0] dout
);

    assign dout = (sel == SRC_A) ? inA : inB;

endmodule

// File: rtl/bus_arbiter_2to1.sv
// Round-robin burst arbiter for two producers sharing one registered 32-bit downstream port.
// Latency: request in IDLE -> grant next edge; accepted beat appears on OutData one edge later.
// Backpressure: granted Ready = !OutValid || OutReady; output stage holds while OutValid && !OutReady.
// Ports: Clk/Rst_n (sync, active-low); InA/InB, ValidA/ValidB, LastA/LastB, ReadyA/ReadyB on the
// request side; Sel drives the shared mux; OutData/OutValid/OutLast/OutSrc/OutReady downstream.
module bus_arbiter_2to1
    import bus_arbiter_2to1_pkg::*;
#(
    parameter int MAX_BEATS = 16
)
(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [DATA_W-1:0] InA,
    input  logic [DATA_W-1:0] InB,
    input  logic              ValidA,
    input  logic              ValidB,
    input  logic              LastA,
    input  logic              LastB,
    output logic              ReadyA,
    output logic              ReadyB,
    output logic              Sel,
    output logic [DATA_W-1:0] OutData,
    output logic              OutValid,
    output logic              OutLast,
    output logic              OutSrc,
    input  logic              OutReady
);

    localparam int            CW       = $clog2(MAX_BEATS);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BEATS - 1);

    arb_state_e        state_q;
    logic              last_grant_q;
    logic [CW-1:0]     beat_cnt_q;
    logic              sel_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic              out_src_q;

    logic [DATA_W-1:0] out_data_d;
    logic              out_free;
    logic              acc_a;
    logic              acc_b;
    logic              in_last;
    logic              eff_last;

    bus_arbiter_2to1_mux u_mux (
        .inA  (InA),
        .inB  (InB),
        .sel  (sel_q),
        .dout (out_data_d)
    );

    // Output slot can take a beat if empty or draining this cycle.
    assign out_free = !out_valid_q || OutReady;
    assign ReadyA   = (state_q == GRANT_A) && out_free;
    assign ReadyB   = (state_q == GRANT_B) && out_free;
    assign acc_a    = ValidA && ReadyA;
    assign acc_b    = ValidB && ReadyB;
    assign in_last  = (state_q == GRANT_A) ? LastA : LastB;
    // Beat counter cap forces the burst closed even without a requester Last.
    assign eff_last = in_last || (beat_cnt_q == CNT_LAST);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= SRC_B;
            beat_cnt_q   <= '0;
            sel_q        <= SRC_B;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_src_q    <= 1'b0;
        end else begin
            // Output stage: load wins over drain, so drain+load in one cycle keeps full rate.
            if (acc_a || acc_b) begin
                out_data_q  <= out_data_d;
                out_valid_q <= 1'b1;
                out_last_q  <= eff_last;
                out_src_q   <= acc_a ? SRC_A : SRC_B;
            end else if (OutReady) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    // A wins contention only if B was served last; Sel moves only here.
                    if (ValidA && (!ValidB || last_grant_q == SRC_B)) begin
                        state_q <= GRANT_A;
                        sel_q   <= SRC_A;
                    end else if (ValidB) begin
                        state_q <= GRANT_B;
                        sel_q   <= SRC_B;
                    end
                end
                GRANT_A, GRANT_B: begin
                    if (acc_a || acc_b) begin
                        if (eff_last) begin
                            state_q      <= IDLE;
                            last_grant_q <= (state_q == GRANT_A) ? SRC_A : SRC_B;
                            beat_cnt_q   <= '0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Sel      = sel_q;
    assign OutData  = out_data_q;
    assign OutValid = out_valid_q;
    assign OutLast  = out_last_q;
    assign OutSrc   = out_src_q;

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Directed bench for bus_arbiter_2to1 with MAX_BEATS = 4: queue-driven requesters, downstream scoreboard.
// Latency: n/a.
// Backpressure: bench drives OutReady directly per test.
module tb_bus_arbiter_2to1;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [31:0] InA = '0, InB = '0;
    logic        ValidA = 1'b0, ValidB = 1'b0, LastA = 1'b0, LastB = 1'b0;
    logic        ReadyA, ReadyB, Sel, OutValid, OutLast, OutSrc;
    logic [31:0] OutData;
    logic        OutReady = 1'b1;

    bus_arbiter_2to1 #(.MAX_BEATS(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .InA(InA), .InB(InB),
        .ValidA(ValidA), .ValidB(ValidB), .LastA(LastA), .LastB(LastB),
        .ReadyA(ReadyA), .ReadyB(ReadyB), .Sel(Sel), .OutData(OutData),
        .OutValid(OutValid), .OutLast(OutLast), .OutSrc(OutSrc), .OutReady(OutReady)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_pass = 0;
    int viol   = 0;
    bit pend_a = 1'b0, pend_b = 1'b0;

    logic [32:0] qa[$], qb[$];          // {last, data} per pending requester beat
    logic [33:0] got[$], expq[$];       // {src, last, data} per downstream beat

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive();
        ValidA = (qa.size() > 0);
        InA    = ValidA ? qa[0][31:0] : '0;
        LastA  = ValidA ? qa[0][32]   : 1'b0;
        ValidB = (qb.size() > 0);
        InB    = ValidB ? qb[0][31:0] : '0;
        LastB  = ValidB ? qb[0][32]   : 1'b0;
    endtask

    // One clock: sample handshakes before the edge, update requester queues after it.
    task automatic cycle();
        bit acc_a, acc_b;
        #1;
        if (pend_a && Rst_n && !ValidA) viol++;
        if (pend_b && Rst_n && !ValidB) viol++;
        acc_a  = Rst_n && ValidA && ReadyA;
        acc_b  = Rst_n && ValidB && ReadyB;
        pend_a = Rst_n && ValidA && !ReadyA;
        pend_b = Rst_n && ValidB && !ReadyB;
        if (Rst_n && OutValid && OutReady) got.push_back({OutSrc, OutLast, OutData});
        @(posedge Clk);
        #1;
        if (acc_a) void'(qa.pop_front());
        if (acc_b) void'(qb.pop_front());
        drive();
    endtask

    task automatic run_until(input int n, input int limit);
        for (int i = 0; i < limit && got.size() < n; i++) cycle();
    endtask

    task automatic ex(input logic src, input logic last, input logic [31:0] d);
        expq.push_back({src, last, d});
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_count"}, 64'(got.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size(); i++)
            if (i < got.size()) chk($sformatf("%s_beat%0d", tag, i), 64'(got[i]), 64'(expq[i]));
        got.delete();
        expq.delete();
    endtask

    initial begin
        bit exp_ov[11];
        exp_ov = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1};

        // ---- reset with both requesters valid; load contention traffic A, B, A ----
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < 3; k++) qa.push_back({k == 2, 32'hA000_0000 + 32'(k)});
        for (int k = 0; k < 3; k++) qb.push_back({k == 2, 32'hB000_0000 + 32'(k)});
        drive();
        for (int i = 0; i < 3; i++) cycle();
        chk("rst_sel", Sel, 0);
        chk("rst_data", OutData, 0);
        chk("rst_valid", OutValid, 0);
        chk("rst_last", OutLast, 0);
        chk("rst_src", OutSrc, 0);
        chk("rst_rdya", ReadyA, 0);
        chk("rst_rdyb", ReadyB, 0);
        Rst_n = 1'b1;
        cycle();
        chk("rel_rdya", ReadyA, 1);
        chk("rel_rdyb", ReadyB, 0);
        chk("rel_sel", Sel, 1);

        // ---- contention: A0..A2, bubble, B0..B2, bubble, A0..A2 ----
        for (int i = 0; i < 11; i++) begin
            cycle();
            chk($sformatf("cont_ov%0d", i), OutValid, exp_ov[i]);
        end
        run_until(9, 10);
        for (int b = 0; b < 3; b++)
            for (int k = 0; k < 3; k++)
                ex(b != 1, k == 2, (b == 1 ? 32'hB000_0000 : 32'hA000_0000) + 32'(k));
        check_stream("cont");

        // ---- backpressure on B's 4-beat burst ----
        for (int k = 1; k <= 4; k++) qb.push_back({k == 4, 32'(k)});
        drive();
        cycle();
        chk("bp_sel", Sel, 0);
        cycle();
        OutReady = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_hold_data%0d", i), OutData, 32'h1);
            chk($sformatf("bp_hold_ov%0d", i), OutValid, 1);
            chk($sformatf("bp_rdyb%0d", i), ReadyB, 0);
            cycle();
        end
        OutReady = 1'b1;
        run_until(4, 20);
        for (int k = 1; k <= 4; k++) ex(1'b0, k == 4, 32'(k));
        check_stream("bp");

        // ---- forced termination at 4 beats, B waiting is served next ----
        for (int k = 1; k <= 6; k++) qa.push_back({k == 6, 32'hC0 + 32'(k)});
        qb.push_back({1'b1, 32'hD1});
        drive();
        run_until(7, 60);
        for (int k = 1; k <= 4; k++) ex(1'b1, k == 4, 32'hC0 + 32'(k));
        ex(1'b0, 1'b1, 32'hD1);
        ex(1'b1, 1'b0, 32'hC5);
        ex(1'b1, 1'b1, 32'hC6);
        check_stream("force");

        // ---- last accept + drain + ValidB rise in the same cycle ----
        qa.push_back({1'b0, 32'hE1});
        qa.push_back({1'b1, 32'hE2});
        drive();
        cycle();
        chk("sim_sel_a", Sel, 1);
        cycle();
        qb.push_back({1'b1, 32'hF1});
        drive();
        cycle();
        chk("sim_idle_rdya", ReadyA, 0);
        chk("sim_idle_rdyb", ReadyB, 0);
        chk("sim_out_data", OutData, 32'hE2);
        chk("sim_out_last", OutLast, 1);
        cycle();
        chk("sim_sel_b", Sel, 0);
        chk("sim_rdyb", ReadyB, 1);
        run_until(3, 10);
        ex(1'b1, 1'b0, 32'hE1);
        ex(1'b1, 1'b1, 32'hE2);
        ex(1'b0, 1'b1, 32'hF1);
        check_stream("sim");

        // ---- reset during beat 2 of A's burst ----
        for (int k = 1; k <= 3; k++) qa.push_back({k == 3, 32'h10 + 32'(k)});
        drive();
        cycle();
        cycle();
        OutReady = 1'b0;
        Rst_n    = 1'b0;
        cycle();
        chk("mrst_valid", OutValid, 0);
        chk("mrst_data", OutData, 0);
        chk("mrst_sel", Sel, 0);
        chk("mrst_rdya", ReadyA, 0);
        chk("mrst_src", OutSrc, 0);
        Rst_n = 1'b1;
        OutReady = 1'b1;
        qa.delete();
        qb.push_back({1'b1, 32'h21});
        drive();
        cycle();
        chk("mrst_grant_sel", Sel, 0);
        chk("mrst_grant_rdyb", ReadyB, 1);
        chk("mrst_grant_rdya", ReadyA, 0);
        run_until(1, 10);
        ex(1'b0, 1'b1, 32'h21);
        check_stream("mrst");

        chk("req_contract", 64'(viol), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_2to1.md
# bus_arbiter_2to1

Two-requester arbiter and sequencer for a shared 32-bit 2-to-1 datapath mux. The block decides which of two sources (A, B) owns a single downstream 32-bit port, drives the mux select (Sel = 1 selects A, Sel = 0 selects B), and moves data through a registered output stage with valid/ready handshakes on both sides. Grants are held for a whole burst (until the last beat) and alternate round-robin under contention. It sits between two producer blocks and one consumer, such as a shared register-file write port or memory write bus.

## Interface
- MAX_BEATS, 16: maximum beats per grant; a burst is force-terminated at this count. Legal range is 2..256.
- Clk  input  1  rising-edge clock
- Rst_n  input  1  synchronous, active-low reset
- InA, InB  input  32  requester data
- ValidA, ValidB  input  1  requester beat valid
- LastA, LastB  input  1  beat is the final one of the burst
- ReadyA, ReadyB  output  1  beat accepted this cycle when Valid and Ready are both high
- Sel  output  1  mux select; 1 selects A, 0 selects B
- OutData  output  32  registered downstream data
- OutValid  output  1  downstream beat valid
- OutLast  output  1  final beat of the burst (includes forced termination)
- OutSrc  output  1  source of the current OutData; 1 = A
- OutReady  input  1  downstream accept

## Operation
- FSM states: IDLE, GRANT_A, GRANT_B.
- IDLE:
  - Only ValidA → GRANT_A. Only ValidB → GRANT_B.
  - Both valid → grant the source not served last, tracked by the LastGrant register. LastGrant resets to B, so A wins the first contention.
  - Neither valid → stay in IDLE.
- GRANT_x: Sel = (x == A). Ready for the granted source is (!OutValid || OutReady). The other source's Ready is 0. Both Readys are 0 in IDLE.
- Accepted beat: the OutData/OutValid/OutLast/OutSrc register loads on the next edge. OutLast = Last_x OR (BeatCnt == MAX_BEATS-1).
- Burst end: an accepted beat with effective last=1 causes transition to IDLE, LastGrant = x, and BeatCnt = 0. Otherwise BeatCnt increments.
- Output register:
  - Holds its contents while OutValid && !OutReady.
  - Clears OutValid when OutReady is high and no new beat is accepted.
  - Simultaneous drain and load is allowed, giving full throughput.
- Valid deasserted mid-burst: the grant is held. There is no timeout other than the beat count.
- Requester contract: Valid must not drop while Ready is 0 and data is pending. The bench checks this; RTL does not enforce it.

## Timing
- Reset (Rst_n = 0 at a rising edge):
  - State = IDLE, LastGrant = B, BeatCnt = 0.
  - Sel = 0, OutData = 0, OutValid = 0, OutLast = 0, OutSrc = 0, ReadyA = ReadyB = 0.
- Reset mid-burst discards any pending output beat. There is no flush.
- Arbitration latency: request seen in IDLE → grant state on the next edge → Ready asserted in that cycle (combinational from state and output occupancy).
- Data latency: input beat accepted at edge N → OutValid at N+1.
- Throughput: one beat per cycle inside a burst while OutReady is held high.
- Bus turnaround: one IDLE bubble cycle after every burst end, including back-to-back bursts from the same source.
- Sel changes only on state transitions. Sel holds its last value in IDLE.

## Structure
- Shared package (team datapath package): FSM state encoding (IDLE=2'b00, GRANT_A=2'b01, GRANT_B=2'b10), SRC_A = 1'b1, SRC_B = 1'b0, DATA_W = 32.
- One natural sub-module: the existing 32-bit 2-to-1 mux. It is instantiated with inA = InA, inB = InB, sel = Sel, and its output feeds the output register.
- BeatCnt width is $clog2(MAX_BEATS).
- Expected size: about 150–250 lines.

## Test plan
- **Reset:** hold Rst_n = 0 for 3 cycles with ValidA = ValidB = 1 → all outputs 0 and ReadyA = ReadyB = 0. On release, the GRANT_A edge follows, then ReadyA = 1.
- **Contention:** A and B each send 3-beat bursts continuously, data 0xA000_000k and 0xB000_000k, OutReady = 1 → output order A0 A1 A2, bubble, B0 B1 B2, bubble, A0…. OutLast is set on every third beat, and OutSrc matches each beat.
- **Backpressure:** B sends a 4-beat burst 0x1..0x4 with OutReady low on cycles 2–4 → OutData holds 0x1 stable. ReadyB = 0 while the output is full. No beat is lost or duplicated.
- **Forced termination:** MAX_BEATS = 4; A sends 6 beats with LastA only on beat 6 → OutLast on beat 4 and grant released. If B is waiting, it is served next. A's beats 5–6 arrive in a later grant.
- **Simultaneous events:** at the cycle A's last beat is accepted, OutReady drains the previous beat and ValidB rises → no data loss. The state goes to IDLE, then GRANT_B.
- **Mid-burst reset:** pulse Rst_n low during beat 2 of A's burst → outputs return to reset values. After release with only ValidB, B is granted first.
